rd_req_arbiter: RTL and testbench
=================================

// Module: rd_req_arbiter
// PURPOSE
//  Round-robin arbiter that shares one rd_channel user command/data port among NUM_REQ requesters.
//  Grants one requester at a time and forwards its command as a single-cycle user_rd_req pulse.
//  Holds the grant until the burst ends (user_rd_last), steering returned read data to the owner only.
//  Sits in the rd_clk domain between user-side clients and rd_channel.
// PARAMETERS
//  NUM_REQ          4     number of requesters, 2..8
//  AXI_ADDR_WIDTH   32    address width, matches rd_channel
//  USER_DATA_WIDTH  16    read data width, matches rd_channel
//  TIMEOUT_CYC      4096  watchdog limit in cycles (used only with RD_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1                   rd_clk domain clock
//  reset           in   1                   synchronous, active-high
//  req_valid       in   NUM_REQ             per-requester command valid
//  req_addr        in   NUM_REQ*AXI_ADDR_WIDTH  packed start addresses, slice i = requester i
//  req_length      in   NUM_REQ*13          packed read lengths
//  req_ready       out  NUM_REQ             one-hot 1-cycle accept pulse
//  rsp_data        out  USER_DATA_WIDTH     read data, broadcast to all requesters
//  rsp_valid       out  NUM_REQ             one-hot data valid for the owner
//  rsp_last        out  NUM_REQ             one-hot last beat for the owner
//  user_rd_req     out  1                   command pulse to rd_channel
//  user_rd_addr    out  AXI_ADDR_WIDTH      latched address of the granted requester
//  user_rd_length  out  13                  latched length of the granted requester
//  user_rd_req_busy in  1                   rd_channel controller busy
//  user_rd_data    in   USER_DATA_WIDTH     from rd_channel
//  user_rd_valid   in   1                   from rd_channel
//  user_rd_last    in   1                   from rd_channel
//  arb_owner       out  3                   index of the current or last granted requester
//  arb_timeout_err out  1                   sticky watchdog flag; tied to 0 without the macro
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, arb_owner=0.
//   All outputs are 0: req_ready, rsp_*, user_rd_req, user_rd_addr, user_rd_length, arb_timeout_err.
//  IDLE:
//   - If any req_valid is high, pick the first set bit scanning upward from the rr pointer (wrapping).
//   - Latch that requester's addr/length into user_rd_addr/user_rd_length and set arb_owner.
//   - Pulse req_ready[owner] for 1 cycle, then go to ISSUE. Grant latency is 1 cycle after req_valid.
//  Requester handshake:
//   - A requester holds req_valid with stable addr/length until it sees req_ready.
//   - Deasserting req_valid before acceptance is legal; that requester is simply not scanned.
//  Zero length: req_length==0 is accepted (req_ready pulses), nothing is issued downstream,
//   the rr pointer advances, and the state returns to IDLE.
//  ISSUE: when user_rd_req_busy==0, drive user_rd_req=1 for exactly one cycle, then go to WAIT_ACK.
//   While busy is high, stay in ISSUE with user_rd_req=0.
//  WAIT_ACK: wait for user_rd_req_busy==1, then go to DATA.
//   If user_rd_valid&user_rd_last arrives here first, treat it as burst end.
//  DATA: rsp_valid[owner]=user_rd_valid and rsp_last[owner]=user_rd_last, combinational pass-through, 0 latency.
//   rsp_data=user_rd_data at all times. Non-owner rsp_valid/rsp_last are always 0.
//  Burst end: user_rd_valid&user_rd_last, then go to IDLE with rr pointer = owner+1 (mod NUM_REQ).
//   A new grant can be issued on the next cycle, with no dead cycle beyond IDLE.
//  Data outside DATA/WAIT_ACK: user_rd_valid while in IDLE/ISSUE is dropped (not forwarded).
//  Simultaneous requests: exactly one grant per IDLE visit. Starvation bound is NUM_REQ-1 bursts.
//  Reset mid-burst: the FSM returns to IDLE immediately.
//   Outstanding rd_channel data is discarded while in IDLE. The rr pointer resets to 0.
// CONFIGURATION
//  RD_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to ISSUE and counts in ISSUE/WAIT_ACK/DATA.
//   - At TIMEOUT_CYC: set arb_timeout_err (sticky until reset), force rsp_last[owner]=1 for 1 cycle
//     with rsp_valid=0, and go to IDLE with the pointer advanced.
//  RD_ARB_TIMEOUT_EN undefined: no counter; arb_timeout_err is constant 0; a grant waits indefinitely.
// TESTING
//  1. Single request: req_valid[1], addr=0x100, len=64.
//     Expect req_ready[1] at +1, user_rd_req pulse with addr 0x100/len 64,
//     and 64 data beats on rsp_valid[1] only.
//  2. All 4 requesters valid continuously.
//     Grants in order 0,1,2,3,0; each next user_rd_req only after the prior user_rd_last.
//  3. busy=1 held 10 cycles while in ISSUE: user_rd_req stays 0,
//     then pulses exactly once the cycle busy falls.
//  4. req_length=0 on requester 2: req_ready[2] pulses, no user_rd_req,
//     next grant goes to requester 3.
//  5. Reset asserted mid-DATA: next cycle all outputs are 0, state IDLE;
//     further user_rd_valid is not forwarded.
//  6. RD_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, busy never rises:
//     at cycle 100 arb_timeout_err=1 and rsp_last[owner] pulses; the next requester is granted.

Source files
------------

// File: rtl/rd_req_arbiter.sv
// rtl/rd_req_arbiter.sv - round-robin arbiter sharing one rd_channel command/data port (optional watchdog: RD_ARB_TIMEOUT_EN)
module rd_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int USER_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYC     = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*13-1:0]             req_length,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [USER_DATA_WIDTH-1:0]        rsp_data,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [NUM_REQ-1:0]                rsp_last,
  output logic                              user_rd_req,
  output logic [AXI_ADDR_WIDTH-1:0]         user_rd_addr,
  output logic [12:0]                       user_rd_length,
  input  logic                              user_rd_req_busy,
  input  logic [USER_DATA_WIDTH-1:0]        user_rd_data,
  input  logic                              user_rd_valid,
  input  logic                              user_rd_last,
  output logic [2:0]                        arb_owner,
  output logic                              arb_timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DATA} state_t;

  // Owner index and pointer are 3 bits wide, and the watchdog counter is 16 bits.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
    $error("rd_req_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
  end

  state_t                    state_q;
  logic [2:0]                rr_q;
  logic [2:0]                owner_q;
  logic [NUM_REQ-1:0]        req_ready_q;
  logic                      user_rd_req_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [12:0]               len_q;

  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        grant_onehot;
  logic [NUM_REQ-1:0]        owner_onehot;
  logic                      grant_found;
  logic [2:0]                grant_idx;
  logic [AXI_ADDR_WIDTH-1:0] grant_addr;
  logic [12:0]               grant_len;
  logic                      fwd_en;
  logic                      burst_end;
  logic                      forced_last;

`ifdef RD_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        to_err_q;
  logic        to_last_q;
  logic        to_hit;

  // The counter is held at zero in IDLE, so it starts from zero on every entry to ISSUE.
  assign to_hit          = (state_q != IDLE) && (to_cnt_q == 16'(TIMEOUT_CYC - 1));
  assign arb_timeout_err = to_err_q;
  assign forced_last     = to_last_q;
`else
  assign arb_timeout_err = 1'b0;
  assign forced_last     = 1'b0;
`endif

  // Slot visited at scan offset 'off' from the round-robin base, wrapping at NUM_REQ.
  function automatic logic [2:0] rr_slot(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 3'(s);
  endfunction

  function automatic logic [2:0] ptr_after(input logic [2:0] idx);
    return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Round-robin scan; the requester accepted last cycle is masked because its valid may still be up.
  always_comb begin
    eligible     = req_valid & ~req_ready_q;
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_addr   = '0;
    grant_len    = '0;
    grant_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && eligible[i] && (rr_slot(rr_q, k) == 3'(i))) begin
          grant_found     = 1'b1;
          grant_idx       = 3'(i);
          grant_addr      = req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          grant_len       = req_length[i*13 +: 13];
          grant_onehot[i] = 1'b1;
        end
      end
    end
  end

  // Response steering: data is forwarded only to the owner and only once the command is out.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_onehot[i] = (owner_q == 3'(i));
    end
    fwd_en    = (state_q == WAIT_ACK) || (state_q == DATA);
    burst_end = fwd_en && user_rd_valid && user_rd_last;
    rsp_valid = (fwd_en && user_rd_valid) ? owner_onehot : '0;
    rsp_last  = ((fwd_en && user_rd_last) || forced_last) ? owner_onehot : '0;
  end

  assign rsp_data       = user_rd_data;
  assign req_ready      = req_ready_q;
  assign user_rd_req    = user_rd_req_q;
  assign user_rd_addr   = addr_q;
  assign user_rd_length = len_q;
  assign arb_owner      = owner_q;

  // Arbitration FSM with registered grant pulse and command pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      owner_q       <= '0;
      req_ready_q   <= '0;
      user_rd_req_q <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
`ifdef RD_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      to_err_q      <= 1'b0;
      to_last_q     <= 1'b0;
`endif
    end else begin
      req_ready_q   <= '0;
      user_rd_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            owner_q     <= grant_idx;
            addr_q      <= grant_addr;
            len_q       <= grant_len;
            req_ready_q <= grant_onehot;
            // A zero-length read is acknowledged but never reaches rd_channel.
            if (grant_len == 13'd0) rr_q <= ptr_after(grant_idx);
            else                    state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!user_rd_req_busy) begin
            user_rd_req_q <= 1'b1;
            state_q       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (burst_end) begin
            rr_q    <= ptr_after(owner_q);
            state_q <= IDLE;
          end else if (user_rd_req_busy) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (burst_end) begin
            rr_q    <= ptr_after(owner_q);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef RD_ARB_TIMEOUT_EN
      to_last_q <= 1'b0;
      if (state_q == IDLE) begin
        to_cnt_q <= '0;
      end else if (to_hit) begin
        to_err_q  <= 1'b1;
        to_last_q <= 1'b1;
        rr_q      <= ptr_after(owner_q);
        state_q   <= IDLE;
      end else begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// tb/tb_rd_req_arbiter.sv - directed self-checking bench for rd_req_arbiter
module tb_rd_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 16;
`ifdef RD_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 4096;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*13-1:0]  req_length;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     rsp_data;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_last;
  logic              user_rd_req;
  logic [AW-1:0]     user_rd_addr;
  logic [12:0]       user_rd_length;
  logic              user_rd_req_busy;
  logic [DW-1:0]     user_rd_data;
  logic              user_rd_valid;
  logic              user_rd_last;
  logic [2:0]        arb_owner;
  logic              arb_timeout_err;

  logic [AW-1:0]     addr_a [NR];
  logic [12:0]       len_a  [NR];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = addr_a[i];
      req_length[i*13 +: 13] = len_a[i];
    end
  end

  rd_req_arbiter #(
    .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .USER_DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_length(req_length),
    .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .user_rd_req(user_rd_req), .user_rd_addr(user_rd_addr), .user_rd_length(user_rd_length),
    .user_rd_req_busy(user_rd_req_busy), .user_rd_data(user_rd_data),
    .user_rd_valid(user_rd_valid), .user_rd_last(user_rd_last),
    .arb_owner(arb_owner), .arb_timeout_err(arb_timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Act as rd_channel for one granted burst: see the pulse, raise busy, return 'beats' beats.
  task automatic serve(input int owner, input logic [AW-1:0] exp_addr,
                       input logic [12:0] exp_len, input int beats);
    int n;
    logic [NR-1:0] oh;
    oh = '0;
    oh[owner] = 1'b1;
    n = 0;
    while (!user_rd_req && n < 50) begin
      step();
      n++;
    end
    check("rd_req_seen", 64'(user_rd_req), 64'd1);
    check("owner", 64'(arb_owner), 64'(owner));
    check("rd_addr", 64'(user_rd_addr), 64'(exp_addr));
    check("rd_len", 64'(user_rd_length), 64'(exp_len));
    step();
    check("rd_req_one_cycle", 64'(user_rd_req), 64'd0);
    user_rd_req_busy = 1'b1;
    step();
    for (int b = 0; b < beats; b++) begin
      user_rd_valid = 1'b1;
      user_rd_last  = (b == beats - 1);
      user_rd_data  = 16'(b * 7 + owner);
      #1;
      check("rsp_valid", 64'(rsp_valid), 64'(oh));
      check("rsp_data", 64'(rsp_data), 64'(b * 7 + owner));
      if (b == beats - 1) begin
        check("rsp_last", 64'(rsp_last), 64'(oh));
        check("no_overlap_req", 64'(user_rd_req), 64'd0);
      end else if (b == 0) begin
        check("rsp_last_mid", 64'(rsp_last), 64'd0);
      end
      step();
    end
    user_rd_valid    = 1'b0;
    user_rd_last     = 1'b0;
    user_rd_req_busy = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [NR-1:0] exp);
    int n;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      step();
      n++;
    end
    check(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int n;
    reset = 1'b1;
    req_valid = '0;
    user_rd_req_busy = 1'b0;
    user_rd_data = '0;
    user_rd_valid = 1'b0;
    user_rd_last = 1'b0;
    for (int i = 0; i < NR; i++) begin
      addr_a[i] = '0;
      len_a[i]  = '0;
    end
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rd_req", 64'(user_rd_req), 64'd0);
    check("rst_rd_addr", 64'(user_rd_addr), 64'd0);
    check("rst_rd_len", 64'(user_rd_length), 64'd0);
    check("rst_owner", 64'(arb_owner), 64'd0);
    check("rst_err", 64'(arb_timeout_err), 64'd0);
    reset = 1'b0;
    step();

`ifdef RD_ARB_TIMEOUT_EN
    // Watchdog: busy never rises, so the grant to requester 0 must time out after TO cycles.
    addr_a[0] = 32'h600; len_a[0] = 13'd8;
    addr_a[1] = 32'h610; len_a[1] = 13'd8;
    req_valid = 4'b0011;
    step();
    check("to_grant0", 64'(req_ready), 64'b0001);
    req_valid = 4'b0010;
    n = 0;
    while (rsp_last == '0 && n < 200) begin
      step();
      n++;
    end
    check("to_cycles", 64'(n), 64'(TO));
    check("to_rsp_last", 64'(rsp_last), 64'b0001);
    check("to_rsp_valid", 64'(rsp_valid), 64'd0);
    check("to_err", 64'(arb_timeout_err), 64'd1);
    step();
    check("to_next_grant", 64'(req_ready), 64'b0010);
    check("to_last_one_cycle", 64'(rsp_last), 64'd0);
    check("to_err_sticky", 64'(arb_timeout_err), 64'd1);
    req_valid = '0;
    do_reset();
    step();
    check("to_err_cleared", 64'(arb_timeout_err), 64'd0);
`endif

    // Single request from requester 1, 64 beats.
    addr_a[1] = 32'h100; len_a[1] = 13'd64;
    req_valid = 4'b0010;
    step();
    check("t1_ready", 64'(req_ready), 64'b0010);
    check("t1_no_req_yet", 64'(user_rd_req), 64'd0);
    req_valid = '0;
    step();
    check("t1_ready_pulse", 64'(req_ready), 64'd0);
    serve(1, 32'h100, 13'd64, 64);
    #1;
    check("t1_idle_rsp", 64'(rsp_valid), 64'd0);

    // All four requesters valid continuously: grants 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      addr_a[i] = 32'h1000 + 32'(i * 16);
      len_a[i]  = 13'(2 + i);
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant("t2_grant_order", 4'(1 << (g % NR)));
      serve(g % NR, 32'h1000 + 32'((g % NR) * 16), 13'(2 + g % NR), 2 + g % NR);
    end
    req_valid = '0;
    step();

    // Busy held in ISSUE for 10 cycles; stray data meanwhile must be dropped.
    addr_a[3] = 32'h300; len_a[3] = 13'd3;
    user_rd_req_busy = 1'b1;
    req_valid = 4'b1000;
    step();
    check("t3_ready", 64'(req_ready), 64'b1000);
    req_valid = '0;
    user_rd_valid = 1'b1;
    user_rd_last = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (user_rd_req) pulses++;
      if (rsp_valid != '0) pulses++;
      step();
    end
    check("t3_quiet_while_busy", 64'(pulses), 64'd0);
    user_rd_valid = 1'b0;
    user_rd_last = 1'b0;
    user_rd_req_busy = 1'b0;
    step();
    check("t3_pulse_after_busy", 64'(user_rd_req), 64'd1);
    serve(3, 32'h300, 13'd3, 3);

    // Zero-length on requester 2: acknowledged, not issued, next grant goes to 3.
    addr_a[2] = 32'h200; len_a[2] = 13'd0;
    addr_a[3] = 32'h340; len_a[3] = 13'd4;
    req_valid = 4'b1100;
    step();
    check("t4_ready2", 64'(req_ready), 64'b0100);
    check("t4_no_req_a", 64'(user_rd_req), 64'd0);
    req_valid = 4'b1000;
    step();
    check("t4_ready3", 64'(req_ready), 64'b1000);
    check("t4_no_req_b", 64'(user_rd_req), 64'd0);
    req_valid = '0;
    serve(3, 32'h340, 13'd4, 4);

    // Reset in the middle of a burst.
    addr_a[0] = 32'h500; len_a[0] = 13'd8;
    req_valid = 4'b0001;
    step();
    check("t5_ready", 64'(req_ready), 64'b0001);
    req_valid = '0;
    step();
    check("t5_pulse", 64'(user_rd_req), 64'd1);
    user_rd_req_busy = 1'b1;
    step();
    user_rd_valid = 1'b1;
    #1;
    check("t5_beat_fwd", 64'(rsp_valid), 64'b0001);
    step();
    reset = 1'b1;
    user_rd_last = 1'b1;
    step();
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_rsp_last", 64'(rsp_last), 64'd0);
    check("t5_rd_req", 64'(user_rd_req), 64'd0);
    check("t5_rd_addr", 64'(user_rd_addr), 64'd0);
    check("t5_rd_len", 64'(user_rd_length), 64'd0);
    check("t5_owner", 64'(arb_owner), 64'd0);
    reset = 1'b0;
    user_rd_last = 1'b0;
    step();
    check("t5_drop_in_idle", 64'(rsp_valid), 64'd0);
    user_rd_valid = 1'b0;
    user_rd_req_busy = 1'b0;
    check("t5_err", 64'(arb_timeout_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
